serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 203 ++++++++++++++++++++
 tb/tb_serial_deserializer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//
// Purpose: receives asynchronous-style serial frames (start bit 0, WIDTH data
// bits LSB first, optional even-parity bit, stop bit 1) from an already
// registered serial line, qualified by a sample strobe, and presents each good
// word on a single-entry valid/ready output buffer.
//
// Build option:
//   PARITY_CHECK_EN  when defined, an even-parity bit follows the data bits
//                    and the parity_err port is present.
//
// Ports:
//   clk         in   rising-edge clock for all state
//   reset       in   asynchronous, active-high reset
//   bit_in      in   registered serial data
//   bit_en      in   sample strobe; bit_in is used only when bit_en=1
//   word_out    out  [WIDTH] assembled data word (LSB received first)
//   word_valid  out  word_out holds an unconsumed word
//   word_ready  in   downstream accepts word_out when word_valid=1
//   overrun     out  one-cycle pulse: completed word dropped, buffer full
//   frame_err   out  one-cycle pulse: stop bit sampled as 0
//   parity_err  out  one-cycle pulse: parity mismatch (PARITY_CHECK_EN only)
// ---------------------------------------------------------------------------
module serial_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             frame_err
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
`ifdef PARITY_CHECK_EN
    S_PARITY = 2'd2,
`endif
    S_STOP   = 2'd3
  } state_t;

  // Registered state
  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_word;
  logic               r_valid;
  logic               r_overrun;
  logic               r_frame_err;
`ifdef PARITY_CHECK_EN
  logic               r_par_bad;
  logic               r_parity_err;
`endif

  // Next-state values
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_word_nxt;
  logic               w_valid_nxt;
  logic               w_overrun_nxt;
  logic               w_frame_err_nxt;
  logic               w_frame_done;
  logic               w_last_bit;
`ifdef PARITY_CHECK_EN
  logic               w_par_bad_nxt;
  logic               w_parity_err_nxt;
`endif

  assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

  // State register: everything updates together; reset clears all state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_shift      <= w_shift_nxt;
      r_word       <= w_word_nxt;
      r_valid      <= w_valid_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_err  <= w_frame_err_nxt;
`ifdef PARITY_CHECK_EN
      r_par_bad    <= w_par_bad_nxt;
      r_parity_err <= w_parity_err_nxt;
`endif
    end
  end

  // Next-state and output logic for the frame receiver and output buffer.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_shift_nxt      = r_shift;
    w_word_nxt       = r_word;
    // A handshake this cycle frees the buffer; a completing frame may refill it.
    w_valid_nxt      = r_valid & ~word_ready;
    w_overrun_nxt    = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_frame_done     = 1'b0;
`ifdef PARITY_CHECK_EN
    w_par_bad_nxt    = r_par_bad;
    w_parity_err_nxt = 1'b0;
`endif

    if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          // Start bit is a sampled 0; idle line (1) keeps waiting.
          if (!bit_in) begin
            w_state_nxt = S_DATA;
            w_count_nxt = '0;
            w_shift_nxt = '0;
          end
        end

        S_DATA: begin
          // Shift register is cleared at start, so OR-ing places the bit.
          w_shift_nxt = r_shift | (WIDTH'(bit_in) << r_count);
          w_count_nxt = r_count + CNT_W'(1);
          if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end

`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          // Even parity: data bits plus parity bit must XOR to 0.
          w_par_bad_nxt = ^{r_shift, bit_in};
          w_state_nxt   = S_STOP;
        end
`endif

        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (!bit_in) begin
            w_frame_err_nxt = 1'b1;
          end else begin
`ifdef PARITY_CHECK_EN
            if (r_par_bad) begin
              w_parity_err_nxt = 1'b1;
            end else begin
              w_frame_done = 1'b1;
            end
`else
            w_frame_done = 1'b1;
`endif
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Load a completed word unless the buffer is still full and not being read.
    if (w_frame_done) begin
      if (r_valid && !word_ready) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_word_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
`ifdef PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

  localparam int unsigned WIDTH = 8;
`ifdef PARITY_CHECK_EN
  localparam int unsigned NBITS = WIDTH + 3;
`else
  localparam int unsigned NBITS = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             bit_in;
  logic             bit_en;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
  logic             frame_err;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model of the output buffer and error pulses.
  logic             exp_valid;
  logic [WIDTH-1:0] exp_word;
  logic             exp_ovr;
  logic             exp_ferr;
  logic             exp_perr;

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Drive at negedge, DUT samples at posedge, observe at next negedge.
  task automatic step(input logic en, input logic b, input logic rdy);
    bit_en     = en;
    bit_in     = b;
    word_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one whole frame; word_ready is held low except in the stop-bit cycle.
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit,
                            input logic par_bit, input int gap_mode,
                            input logic rdy_stop, output logic valid_pre,
                            output int steps);
    logic [NBITS-1:0] seq;
    seq[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) seq[i+1] = data[i];
`ifdef PARITY_CHECK_EN
    seq[WIDTH+1] = par_bit;
`endif
    seq[NBITS-1] = stop_bit;
    steps     = 0;
    valid_pre = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      if (gap_mode == 2 && k > 0) begin
        int ng;
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
          steps++;
        end
      end
      if (k == NBITS - 1) begin
        valid_pre = word_valid;
        step(1'b1, seq[k], rdy_stop);
      end else begin
        step(1'b1, seq[k], 1'b0);
      end
      steps++;
      if (gap_mode == 1 && k < NBITS - 1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        steps++;
      end
    end
  endtask

  // Expected effect of a frame completing, given ready in the stop-bit cycle.
  task automatic model_frame(input logic [WIDTH-1:0] data, input logic stop_ok,
                             input logic par_ok, input logic rdy);
    logic consumed;
    consumed = exp_valid && rdy;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    if (!stop_ok) begin
      exp_ferr = 1'b1;
      if (consumed) exp_valid = 1'b0;
    end else if (!par_ok) begin
      exp_perr = 1'b1;
      if (consumed) exp_valid = 1'b0;
    end else if (exp_valid && !rdy) begin
      exp_ovr = 1'b1;
    end else begin
      exp_valid = 1'b1;
      exp_word  = data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_en = 1'b1; bit_in = 1'b0; word_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || word_out !== '0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b word=%h ovr=%b ferr=%b, required 0 0 0 0",
               word_valid, word_out, overrun, frame_err);
    end
`ifdef PARITY_CHECK_EN
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity_err: got %b required 0", parity_err);
    end
`endif
    reset = 1'b0; bit_en = 1'b0; bit_in = 1'b1; word_ready = 1'b0;
    exp_valid = 1'b0; exp_word = '0;
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_basic();
    logic vpre; int steps;
    send_frame(8'h4A, 1'b1, ^8'h4A, 0, 1'b0, vpre, steps);
    checks++;
    if (vpre !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b required 0", vpre);
    end
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h4A) begin
      errors++; $display("FAIL basic_word: valid=%b word=%h required 1 4a", word_valid, word_out);
    end
    checks++;
    if (steps != NBITS || overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_timing_pulses: steps=%0d ovr=%b ferr=%b required %0d 0 0",
               steps, overrun, frame_err, NBITS);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: valid=%b required 0", word_valid);
    end
    exp_valid = 1'b0;
  endtask

  task automatic test_toggle();
    logic vpre; int steps;
    send_frame(8'h4A, 1'b1, ^8'h4A, 1, 1'b0, vpre, steps);
    checks++;
    if (vpre !== 1'b0 || steps != 2 * NBITS - 1) begin
      errors++;
      $display("FAIL toggle_timing: valid_pre=%b steps=%0d required 0 %0d", vpre, steps, 2 * NBITS - 1);
    end
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h4A || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL toggle_word: valid=%b word=%h ferr=%b required 1 4a 0", word_valid, word_out, frame_err);
    end
    step(1'b0, 1'b1, 1'b1);
    exp_valid = 1'b0;
  endtask

  task automatic test_frame_err();
    logic vpre; int steps;
    send_frame(8'hA5, 1'b0, ^8'hA5, 0, 1'b0, vpre, steps);
    checks++;
    if (frame_err !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL frame_err_pulse: ferr=%b valid=%b required 1 0", frame_err, word_valid);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b0 || word_valid !== 1'b0) begin
      errors++; $display("FAIL frame_err_clear: ferr=%b valid=%b required 0 0", frame_err, word_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic vpre; int steps;
    send_frame(8'h11, 1'b1, ^8'h11, 0, 1'b0, vpre, steps);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h11 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: valid=%b word=%h ovr=%b required 1 11 0", word_valid, word_out, overrun);
    end
    send_frame(8'h22, 1'b1, ^8'h22, 0, 1'b0, vpre, steps);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: valid=%b word=%h ovr=%b required 1 11 1", word_valid, word_out, overrun);
    end
    send_frame(8'h33, 1'b1, ^8'h33, 0, 1'b1, vpre, steps);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h33 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake_load: valid=%b word=%h ovr=%b required 1 33 0", word_valid, word_out, overrun);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h33 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: valid=%b word=%h ovr=%b required 1 33 0", word_valid, word_out, overrun);
    end
    step(1'b0, 1'b1, 1'b1);
    exp_valid = 1'b0;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    logic vpre; int steps;
    send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, vpre, steps);
    checks++;
    if (parity_err !== 1'b1 || word_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: perr=%b valid=%b ferr=%b required 1 0 0", parity_err, word_valid, frame_err);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_clear: perr=%b required 0", parity_err);
    end
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, vpre, steps);
    checks++;
    if (parity_err !== 1'b0 || word_valid !== 1'b1 || word_out !== 8'h07) begin
      errors++;
      $display("FAIL parity_good: perr=%b valid=%b word=%h required 0 1 07", parity_err, word_valid, word_out);
    end
    step(1'b0, 1'b1, 1'b1);
    exp_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    logic vpre; int steps;
    send_frame(8'h5C, 1'b1, ^8'h5C, 0, 1'b0, vpre, steps);
    // Start bit plus four data bits of an abandoned frame.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (word_valid !== 1'b0 || word_out !== '0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b word=%h ovr=%b ferr=%b required 0 0 0 0",
               word_valid, word_out, overrun, frame_err);
    end
    bit_en = 1'b1; bit_in = 1'b0; word_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || word_out !== '0) begin
      errors++; $display("FAIL reset_hold: valid=%b word=%h required 0 00", word_valid, word_out);
    end
    reset = 1'b0;
    exp_valid = 1'b0; exp_word = '0;
    send_frame(8'h0F, 1'b1, ^8'h0F, 0, 1'b0, vpre, steps);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 8'h0F || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: valid=%b word=%h ferr=%b ovr=%b required 1 0f 0 0",
               word_valid, word_out, frame_err, overrun);
    end
    step(1'b0, 1'b1, 1'b1);
    exp_valid = 1'b0;
  endtask

  task automatic test_random();
    logic vpre; int steps;
    for (int f = 0; f < 60; f++) begin
      logic [WIDTH-1:0] data;
      logic stop_ok, par_ok, rdy;
      int mode, nidle;
      data    = WIDTH'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef PARITY_CHECK_EN
      par_ok  = ($urandom_range(0, 7) != 0);
`else
      par_ok  = 1'b1;
`endif
      mode    = $urandom_range(0, 2);
      rdy     = 1'($urandom_range(0, 1));
      send_frame(data, stop_ok, (^data) ^ ~par_ok, mode, rdy, vpre, steps);
      model_frame(data, stop_ok, par_ok, rdy);
      checks++;
      if (word_valid !== exp_valid || (exp_valid && word_out !== exp_word) ||
          overrun !== exp_ovr || frame_err !== exp_ferr) begin
        errors++;
        $display("FAIL random_frame%0d: valid=%b word=%h ovr=%b ferr=%b required %b %h %b %b",
                 f, word_valid, word_out, overrun, frame_err, exp_valid, exp_word, exp_ovr, exp_ferr);
      end
`ifdef PARITY_CHECK_EN
      checks++;
      if (parity_err !== exp_perr) begin
        errors++;
        $display("FAIL random_parity%0d: perr=%b required %b", f, parity_err, exp_perr);
      end
`endif
      nidle = $urandom_range(0, 2);
      for (int i = 0; i < nidle; i++) begin
        logic r;
        r = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), 1'b1, r);
        if (exp_valid && r) exp_valid = 1'b0;
        checks++;
        if (word_valid !== exp_valid || overrun !== 1'b0 || frame_err !== 1'b0) begin
          errors++;
          $display("FAIL random_idle%0d: valid=%b ovr=%b ferr=%b required %b 0 0",
                   f, word_valid, overrun, frame_err, exp_valid);
        end
      end
    end
  endtask

  initial begin
    exp_valid = 1'b0; exp_word = '0;
    exp_ovr = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_frame_err();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
